// File: rtl/cache_pkg.sv
// Shared width helpers and flush FSM encoding for the set-associative cache.
package cache_pkg;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } flush_state_e;

  // Ceiling log2, evaluated at elaboration for width derivation.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sets_f(input int cache_size, input int block_size, input int ways);
    return (cache_size * 8) / (block_size * ways);
  endfunction

  function automatic int offset_w_f(input int block_size, input int data_width);
    return log2(block_size / data_width);
  endfunction

  function automatic int index_w_f(input int cache_size, input int block_size, input int ways);
    return log2(sets_f(cache_size, block_size, ways));
  endfunction

  function automatic int tag_w_f(input int addr_width, input int index_w, input int offset_w);
    return addr_width - index_w - offset_w;
  endfunction

  function automatic int way_w_f(input int ways);
    return (ways > 1) ? log2(ways) : 1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU: victim walk and MRU update over WAYS-1 node bits (heap order).
module plru_tree
  import cache_pkg::*;
#(
  parameter  int WAYS = 2,
  localparam int LVLS = log2(WAYS)
) (
  input  logic [WAYS-2:0] i_bits,
  input  logic [LVLS-1:0] i_way,
  output logic [LVLS-1:0] o_victim,
  output logic [WAYS-2:0] o_bits
);

  // Node bit 0 points left (LRU side), 1 points right; children of n are 2n+1, 2n+2.
  always_comb begin
    int node;
    int nxt;
    o_victim = '0;
    o_bits   = i_bits;
    node     = 0;
    nxt      = 0;
    for (int l = 0; l < LVLS; l++) begin
      nxt = node;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) begin
          o_victim[LVLS-1-l] = i_bits[n];
          nxt = 2 * n + 1 + (i_bits[n] ? 1 : 0);
        end
      end
      node = nxt;
    end

    node = 0;
    for (int l = 0; l < LVLS; l++) begin
      nxt = node;
      for (int n = 0; n < WAYS - 1; n++) begin
        if (n == node) begin
          o_bits[n] = ~i_way[LVLS-1-l];
          nxt = 2 * n + 1 + (i_way[LVLS-1-l] ? 1 : 0);
        end
      end
      node = nxt;
    end
  end

endmodule

// File: rtl/cache_assoc_memory.sv
// Set-associative tag/data store: single-cycle lookup with read-before-write fill,
// registered response one cycle after acceptance; req_ready low only during post-reset flush.
module cache_assoc_memory
  import cache_pkg::*;
#(
  parameter  int ADDR_WIDTH = 28,
  parameter  int DATA_WIDTH = 32,
  parameter  int BLOCK_SIZE = 256,
  parameter  int CACHE_SIZE = 65536,
  parameter  int WAYS       = 2,
  localparam int SETS       = sets_f(CACHE_SIZE, BLOCK_SIZE, WAYS),
  localparam int OFFSET_W   = offset_w_f(BLOCK_SIZE, DATA_WIDTH),
  localparam int INDEX_W    = index_w_f(CACHE_SIZE, BLOCK_SIZE, WAYS),
  localparam int TAG_W      = tag_w_f(ADDR_WIDTH, INDEX_W, OFFSET_W),
  localparam int WAY_W      = way_w_f(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_en,
  input  logic [BLOCK_SIZE-1:0] data_write,
  input  logic                  dirty_write,
  output logic                  rsp_valid,
  output logic                  hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic [BLOCK_SIZE-1:0] data_read,
  output logic                  victim_valid,
  output logic                  victim_dirty,
  output logic [TAG_W-1:0]      victim_tag
);

  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  flush_state_e        r_state;
  flush_state_e        w_state_nxt;
  logic [INDEX_W-1:0]  r_flush_idx;
  logic [INDEX_W-1:0]  w_flush_idx_nxt;

  logic [BLOCK_SIZE-1:0] r_data  [WAYS][SETS];
  logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  logic [PLRU_W-1:0]     r_plru  [SETS];

  logic                  w_acc;
  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [WAYS-1:0]       w_hit_vec;
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_inv_way;
  logic                  w_any_inv;
  logic [WAY_W-1:0]      w_plru_victim;
  logic [PLRU_W-1:0]     w_plru_nxt;
  logic [WAY_W-1:0]      w_way;
  logic [BLOCK_SIZE-1:0] w_rd_data;

  // Flush FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FLUSH;
      r_flush_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_idx <= w_flush_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_idx_nxt = r_flush_idx;
    case (r_state)
      ST_FLUSH: begin
        w_flush_idx_nxt = r_flush_idx + INDEX_W'(1);
        if (r_flush_idx == INDEX_W'(SETS - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_FLUSH;
    endcase
  end

  // Gated by rst_n so nothing is accepted in the first reset cycle either.
  assign req_ready = rst_n && (r_state == ST_RUN);
  assign w_acc     = req_valid && req_ready;

  assign w_tag = addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_idx = addr[OFFSET_W +: INDEX_W];

  generate
    if (OFFSET_W > 0) begin : g_offset
      logic w_unused_offset;
      assign w_unused_offset = ^addr[OFFSET_W-1:0];
    end
  endgenerate

  // Lookup: tag match, then lowest-index invalid way as the fill candidate.
  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag);
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_way = WAY_W'(w);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_hit = |w_hit_vec;

  always_comb begin
    w_way = '0;
    if (WAYS > 1) begin
      if (w_hit)          w_way = w_hit_way;
      else if (w_any_inv) w_way = w_inv_way;
      else                w_way = w_plru_victim;
    end
  end

  assign w_rd_data = r_data[w_way][w_idx];

  generate
    if (WAYS > 1) begin : g_plru
      logic [PLRU_W-1:0] w_plru_cur;
      assign w_plru_cur = r_plru[w_idx];
      plru_tree #(.WAYS(WAYS)) u_plru_tree (
        .i_bits   (w_plru_cur),
        .i_way    (w_way),
        .o_victim (w_plru_victim),
        .o_bits   (w_plru_nxt)
      );
    end else begin : g_direct
      assign w_plru_victim = '0;
      assign w_plru_nxt    = '0;
    end
  endgenerate

  // Line storage: no reset, written only on accepted fills.
  always_ff @(posedge clk) begin
    if (w_acc && write_en) begin
      r_data[w_way][w_idx] <= data_write;
      r_tag[w_way][w_idx]  <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_FLUSH) begin
      r_valid[r_flush_idx] <= '0;
      r_dirty[r_flush_idx] <= '0;
      r_plru[r_flush_idx]  <= '0;
    end else if (w_acc) begin
      if (write_en) begin
        r_valid[w_idx][w_way] <= 1'b1;
        r_dirty[w_idx][w_way] <= dirty_write;
      end
      if (write_en || w_hit) r_plru[w_idx] <= w_plru_nxt;
    end
  end

  // Response reports the selected way's contents as they were before this request's write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      hit          <= 1'b0;
      rsp_way      <= '0;
      data_read    <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag   <= '0;
    end else begin
      rsp_valid <= w_acc;
      if (w_acc) begin
        hit          <= w_hit;
        rsp_way      <= w_way;
        data_read    <= w_rd_data;
        victim_valid <= r_valid[w_idx][w_way];
        victim_dirty <= r_dirty[w_idx][w_way];
        victim_tag   <= r_tag[w_way][w_idx];
      end
    end
  end

endmodule

// File: tb/tb_cache_assoc_memory.sv
// Directed bench for cache_assoc_memory at default parameters (1024 sets, 2 ways, tag at addr[27:13]).
module tb_cache_assoc_memory;

  localparam int SETS = 1024;
  localparam logic [255:0] DA5 = {8{32'hA5A5_A5A5}};
  localparam logic [255:0] D1  = {8{32'h1111_1111}};
  localparam logic [255:0] D2  = {8{32'h2222_2222}};
  localparam logic [255:0] D3  = {8{32'h3333_3333}};
  localparam logic [255:0] D4  = {8{32'h4444_4444}};
  localparam logic [255:0] D5  = {8{32'h5555_5555}};
  localparam logic [255:0] D6  = {8{32'h6666_6666}};
  localparam logic [255:0] D7  = {8{32'h7777_7777}};

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [27:0]  addr;
  logic         write_en;
  logic [255:0] data_write;
  logic         dirty_write;
  logic         rsp_valid;
  logic         hit;
  logic [0:0]   rsp_way;
  logic [255:0] data_read;
  logic         victim_valid;
  logic         victim_dirty;
  logic [14:0]  victim_tag;

  int total;
  int bad;
  int cnt;

  cache_assoc_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .addr         (addr),
    .write_en     (write_en),
    .data_write   (data_write),
    .dirty_write  (dirty_write),
    .rsp_valid    (rsp_valid),
    .hit          (hit),
    .rsp_way      (rsp_way),
    .data_read    (data_read),
    .victim_valid (victim_valid),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input int tag, input int idx);
    return 28'((tag << 13) | (idx << 3));
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic wr, input logic [27:0] a, input logic [255:0] d, input logic dt);
    req_valid   = 1'b1;
    write_en    = wr;
    addr        = a;
    data_write  = d;
    dirty_write = dt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    write_en  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush(input string tag);
    cnt = 0;
    while (!req_ready && cnt < 5000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk(tag, 256'(cnt), 256'(SETS));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    write_en = 1'b0;
    addr = '0;
    data_write = '0;
    dirty_write = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_hit", 256'(hit), 256'(0));
    chk("rst_rsp_way", 256'(rsp_way), 256'(0));
    chk("rst_data", data_read, 256'(0));
    chk("rst_vvalid", 256'(victim_valid), 256'(0));
    chk("rst_vdirty", 256'(victim_dirty), 256'(0));
    chk("rst_vtag", 256'(victim_tag), 256'(0));
    chk("rst_ready", 256'(req_ready), 256'(0));

    // Flush takes exactly SETS cycles after release
    rst_n = 1'b1;
    #1;
    chk("flush_ready_low", 256'(req_ready), 256'(0));
    wait_flush("flush_len");
    chk("ready_after_flush", 256'(req_ready), 256'(1));

    // Read after flush misses
    req(1'b0, mk(7, 100), '0, 1'b0);
    chk("cold_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("cold_hit", 256'(hit), 256'(0));
    chk("cold_vvalid", 256'(victim_valid), 256'(0));
    idle();
    chk("idle_rsp_valid", 256'(rsp_valid), 256'(0));

    // Write 0x100 then read it back
    req(1'b1, 28'h0000100, DA5, 1'b1);
    chk("wr100_hit", 256'(hit), 256'(0));
    chk("wr100_way", 256'(rsp_way), 256'(0));
    chk("wr100_vvalid", 256'(victim_valid), 256'(0));
    req(1'b0, 28'h0000100, '0, 1'b0);
    chk("rd100_hit", 256'(hit), 256'(1));
    chk("rd100_way", 256'(rsp_way), 256'(0));
    chk("rd100_data", data_read, DA5);
    chk("rd100_vdirty", 256'(victim_dirty), 256'(1));
    chk("rd100_vvalid", 256'(victim_valid), 256'(1));
    idle();
    chk("hold_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("hold_data", data_read, DA5);

    // PLRU replacement in set 4
    req(1'b1, mk(1, 4), D1, 1'b0);
    chk("s4_fill1_way", 256'(rsp_way), 256'(0));
    req(1'b1, mk(2, 4), D2, 1'b0);
    chk("s4_fill2_way", 256'(rsp_way), 256'(1));
    chk("s4_fill2_hit", 256'(hit), 256'(0));
    req(1'b0, mk(1, 4), '0, 1'b0);
    chk("s4_rd1_hit", 256'(hit), 256'(1));
    chk("s4_rd1_way", 256'(rsp_way), 256'(0));
    chk("s4_rd1_data", data_read, D1);
    req(1'b1, mk(3, 4), D3, 1'b1);
    chk("s4_fill3_hit", 256'(hit), 256'(0));
    chk("s4_fill3_way", 256'(rsp_way), 256'(1));
    chk("s4_fill3_vtag", 256'(victim_tag), 256'(2));
    chk("s4_fill3_vvalid", 256'(victim_valid), 256'(1));
    chk("s4_fill3_data", data_read, D2);

    // Read misses must not move PLRU; a hit must
    req(1'b0, mk(9, 4), '0, 1'b0);
    chk("s4_miss1_way", 256'(rsp_way), 256'(0));
    chk("s4_miss1_vtag", 256'(victim_tag), 256'(1));
    req(1'b0, mk(9, 4), '0, 1'b0);
    chk("s4_miss2_way", 256'(rsp_way), 256'(0));
    req(1'b0, mk(1, 4), '0, 1'b0);
    chk("s4_rehit_way", 256'(rsp_way), 256'(0));
    req(1'b0, mk(9, 4), '0, 1'b0);
    chk("s4_miss3_way", 256'(rsp_way), 256'(1));
    chk("s4_miss3_vtag", 256'(victim_tag), 256'(3));
    chk("s4_miss3_vdirty", 256'(victim_dirty), 256'(1));

    // Back-to-back same-set write then read
    req(1'b1, mk(5, 7), D4, 1'b0);
    chk("b2b_w1_hit", 256'(hit), 256'(0));
    req(1'b0, mk(5, 7), '0, 1'b0);
    chk("b2b_r1_hit", 256'(hit), 256'(1));
    chk("b2b_r1_data", data_read, D4);
    req(1'b1, mk(5, 7), D5, 1'b1);
    chk("b2b_w2_hit", 256'(hit), 256'(1));
    chk("b2b_w2_prewrite", data_read, D4);
    chk("b2b_w2_vdirty", 256'(victim_dirty), 256'(0));
    req(1'b0, mk(5, 7), '0, 1'b0);
    chk("b2b_r2_data", data_read, D5);
    chk("b2b_r2_vdirty", 256'(victim_dirty), 256'(1));
    req(1'b1, mk(6, 7), D6, 1'b0);
    chk("b2b_w3_way", 256'(rsp_way), 256'(1));
    req(1'b0, mk(6, 7), '0, 1'b0);
    chk("b2b_r3_hit", 256'(hit), 256'(1));
    chk("b2b_r3_way", 256'(rsp_way), 256'(1));
    chk("b2b_r3_data", data_read, D6);

    // Reset one cycle after a write request
    req(1'b1, mk(5, 7), D7, 1'b1);
    chk("pre_rst_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("pre_rst_data", data_read, D5);
    req_valid = 1'b0;
    write_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 256'(req_ready), 256'(0));
    @(posedge clk);
    #1;
    chk("mid_rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("mid_rst_hit", 256'(hit), 256'(0));
    chk("mid_rst_data", data_read, 256'(0));
    chk("mid_rst_vvalid", 256'(victim_valid), 256'(0));
    rst_n = 1'b1;
    wait_flush("reflush_len");
    req(1'b0, mk(5, 7), '0, 1'b0);
    chk("post_rst_hit", 256'(hit), 256'(0));
    chk("post_rst_vvalid", 256'(victim_valid), 256'(0));
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
